// File: rtl/apb_mem_slave_p.sv
// APB4-subset scratch-RAM slave: DEPTH words of DATA_WIDTH bits, byte strobes,
// WAIT_STATES wait cycles per access, PSLVERR on out-of-range/misaligned.
// Ports: pclk, preset (async, active-high), paddr, psel, penable, pwrite,
//   pwdata, pstrb -> prdata, pready, pslverr (all driven from registers).
module apb_mem_slave_p #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(BYTES - 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [IW-1:0]         a_idx;
  logic                  a_wr;
  logic                  a_err;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [BYTES-1:0]      a_strb;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  setup;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] widx;
  logic [IW-1:0]         ridx;
  logic                  misal;
  logic                  err;

  assign setup = psel & ~penable;
  assign abort = ~psel | ~penable;
  assign widx  = paddr >> LSB;
  assign ridx  = widx[IW-1:0];
  // AMASK is zero for 8-bit data, so misalignment never fires there
  assign misal = |(paddr & AMASK);
  assign err   = ({1'b0, widx} >= DEPTH_L) | misal;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_idx   <= '0;
      a_wr    <= 1'b0;
      a_err   <= 1'b0;
      a_wdata <= '0;
      a_strb  <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          if (setup) begin
            a_idx   <= ridx;
            a_wr    <= pwrite;
            a_err   <= err;
            a_wdata <= pwdata;
            a_strb  <= pstrb;
            cnt     <= WS;
            if (!pwrite) begin
              prdata <= err ? '0 : mem[ridx];
            end
            // pready is registered: raise it on entry
            // when no wait cycles are configured
            pready  <= (WS == 4'd0);
            pslverr <= (WS == 4'd0) & err;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (abort) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt     <= cnt - 4'd1;
            pready  <= (cnt == 4'd1);
            pslverr <= (cnt == 4'd1) & a_err;
          end else begin
            if (a_wr && !a_err) begin
              for (int b = 0; b < BYTES; b++) begin
                if (a_strb[b]) begin
                  mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
                end
              end
            end
            pready  <= 1'b0;
            pslverr <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
